// File: rtl/multi_port_cache_arbiter_pkg.sv
// Shared types and helpers for the multi-port cache arbiter.
package arbiter_pkg;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} arb_state_t;

  localparam int POLICY_FIXED = 0;
  localparam int POLICY_RR    = 1;

  // Width of an index able to address n ports (at least 1 bit).
  function automatic int idx_w(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/multi_port_cache_arbiter_picker.sv
// Combinational winner selection: fixed priority or round-robin after rr_last.
module rr_priority_picker
  import arbiter_pkg::*;
#(
  parameter int NUM_PORTS = 2,
  parameter int IDX_W     = idx_w(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [IDX_W-1:0]     rr_last,
  input  logic                 policy,
  output logic                 valid,
  output logic [IDX_W-1:0]     winner
);

  logic found;

  always_comb begin
    valid  = |req;
    winner = '0;
    found  = 1'b0;
    // Round-robin takes the first requester above rr_last; the second pass wraps to the lowest.
    if (policy) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (!found && req[i] && (i > int'(rr_last))) begin
          found  = 1'b1;
          winner = IDX_W'(i);
        end
      end
    end
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (!found && req[i]) begin
        found  = 1'b1;
        winner = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/multi_port_cache_arbiter.sv
// N-port line-granular arbiter onto one registered downstream port toward L2.
module multi_port_cache_arbiter
  import arbiter_pkg::*;
#(
  parameter int NUM_PORTS = 2,
  parameter int LINE_W    = 256,
  parameter int ADDR_W    = 32,
  parameter int POLICY    = 1
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [NUM_PORTS-1:0]          req_read,
  input  logic [NUM_PORTS-1:0]          req_write,
  input  logic [NUM_PORTS*ADDR_W-1:0]   req_addr,
  input  logic [NUM_PORTS*LINE_W-1:0]   req_wdata,
  output logic [LINE_W-1:0]             req_rdata,
  output logic [NUM_PORTS-1:0]          req_resp,
  output logic [NUM_PORTS-1:0]          port_active,
  output logic                          mem_read,
  output logic                          mem_write,
  output logic [ADDR_W-1:0]             mem_address,
  output logic [LINE_W-1:0]             mem_wdata,
  input  logic [LINE_W-1:0]             mem_rdata,
  input  logic                          mem_resp
);

  localparam int IDX_W = idx_w(NUM_PORTS);

  arb_state_t           state, state_nxt;
  logic [NUM_PORTS-1:0] req_any;
  logic                 pick_valid;
  logic [IDX_W-1:0]     pick_idx, grant_q, rr_last;

  assign req_any   = req_read | req_write;
  assign req_rdata = mem_rdata;

  rr_priority_picker #(
    .NUM_PORTS(NUM_PORTS),
    .IDX_W    (IDX_W)
  ) u_picker (
    .req    (req_any),
    .rr_last(rr_last),
    .policy (POLICY == POLICY_RR),
    .valid  (pick_valid),
    .winner (pick_idx)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    req_resp  = '0;
    case (state)
      IDLE: if (pick_valid) state_nxt = BUSY;
      BUSY: if (mem_resp) begin
        state_nxt = DONE;
        req_resp  = port_active;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Command is captured once at grant; requester changes during BUSY are not seen downstream.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
      mem_address <= '0;
      mem_wdata   <= '0;
      port_active <= '0;
      grant_q     <= '0;
      rr_last     <= IDX_W'(NUM_PORTS - 1);
    end else begin
      case (state)
        IDLE: if (pick_valid) begin
          grant_q     <= pick_idx;
          mem_write   <= req_write[pick_idx];
          mem_read    <= req_read[pick_idx] & ~req_write[pick_idx];
          mem_address <= req_addr[pick_idx*ADDR_W +: ADDR_W];
          mem_wdata   <= req_wdata[pick_idx*LINE_W +: LINE_W];
          port_active <= NUM_PORTS'(1) << pick_idx;
        end
        BUSY: if (mem_resp) begin
          mem_read    <= 1'b0;
          mem_write   <= 1'b0;
          port_active <= '0;
          rr_last     <= grant_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multi_port_cache_arbiter.sv
// Three arbiters (2-port RR, 2-port fixed, 4-port RR) against a transaction-level reference model.
module tb_multi_port_cache_arbiter;

  localparam int NI = 3;
  localparam int AW = 32;
  localparam int LW = 256;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic [3:0]      rd [NI];
  logic [3:0]      wr [NI];
  logic [4*AW-1:0] ad [NI];
  logic [4*LW-1:0] wd [NI];
  logic [LW-1:0]   mrd [NI];
  logic            mresp [NI];

  logic [LW-1:0] o_rdata [NI];
  logic [LW-1:0] o_mwd [NI];
  logic [AW-1:0] o_ma [NI];
  logic          o_mr [NI];
  logic          o_mw [NI];
  logic [3:0]    o_resp [NI];
  logic [3:0]    o_act [NI];
  logic [1:0]    a_resp, a_act, f_resp, f_act;
  logic [3:0]    q_resp, q_act;

  assign o_resp[0] = {2'b00, a_resp};
  assign o_act[0]  = {2'b00, a_act};
  assign o_resp[1] = {2'b00, f_resp};
  assign o_act[1]  = {2'b00, f_act};
  assign o_resp[2] = q_resp;
  assign o_act[2]  = q_act;

  multi_port_cache_arbiter #(.NUM_PORTS(2), .LINE_W(LW), .ADDR_W(AW), .POLICY(1)) dut_rr2 (
    .clk(clk), .reset_n(reset_n), .req_read(rd[0][1:0]), .req_write(wr[0][1:0]),
    .req_addr(ad[0][2*AW-1:0]), .req_wdata(wd[0][2*LW-1:0]), .req_rdata(o_rdata[0]),
    .req_resp(a_resp), .port_active(a_act), .mem_read(o_mr[0]), .mem_write(o_mw[0]),
    .mem_address(o_ma[0]), .mem_wdata(o_mwd[0]), .mem_rdata(mrd[0]), .mem_resp(mresp[0]));

  multi_port_cache_arbiter #(.NUM_PORTS(2), .LINE_W(LW), .ADDR_W(AW), .POLICY(0)) dut_fix2 (
    .clk(clk), .reset_n(reset_n), .req_read(rd[1][1:0]), .req_write(wr[1][1:0]),
    .req_addr(ad[1][2*AW-1:0]), .req_wdata(wd[1][2*LW-1:0]), .req_rdata(o_rdata[1]),
    .req_resp(f_resp), .port_active(f_act), .mem_read(o_mr[1]), .mem_write(o_mw[1]),
    .mem_address(o_ma[1]), .mem_wdata(o_mwd[1]), .mem_rdata(mrd[1]), .mem_resp(mresp[1]));

  multi_port_cache_arbiter #(.NUM_PORTS(4), .LINE_W(LW), .ADDR_W(AW), .POLICY(1)) dut_rr4 (
    .clk(clk), .reset_n(reset_n), .req_read(rd[2]), .req_write(wr[2]),
    .req_addr(ad[2]), .req_wdata(wd[2]), .req_rdata(o_rdata[2]),
    .req_resp(q_resp), .port_active(q_act), .mem_read(o_mr[2]), .mem_write(o_mw[2]),
    .mem_address(o_ma[2]), .mem_wdata(o_mwd[2]), .mem_rdata(mrd[2]), .mem_resp(mresp[2]));

  int nvec = 0;
  int nerr = 0;
  int cyc  = 0;

  // reference model state, one slot per instance
  bit            m_busy [NI];
  int            m_g [NI];
  int            m_last [NI];
  int            m_free [NI];
  logic [3:0]    p_rd [NI];
  logic [3:0]    p_wr [NI];
  logic [4*AW-1:0] p_ad [NI];
  logic [4*LW-1:0] p_wd [NI];
  bit            e_w [NI];
  logic [AW-1:0] e_ma [NI];
  logic [LW-1:0] e_wd [NI];
  int            glog [NI][128];
  int            gn [NI];

  // memory responder and requester behaviour
  bit            r_en [NI];
  bit            r_pend [NI];
  int            r_cnt [NI];
  int            r_lat [NI];
  logic [LW-1:0] r_data [NI];
  bit            drop [NI];
  bit            rnd [NI];
  logic [3:0]    to_drop [NI];

  function automatic int np(input int m);
    return (m == 2) ? 4 : 2;
  endfunction

  function automatic int pol(input int m);
    return (m == 1) ? 0 : 1;
  endfunction

  // Spec rule: scan upward from last+1 modulo n (RR), or from port 0 (fixed).
  function automatic int pick(input logic [3:0] r, input int last, input int n, input int p);
    for (int k = 0; k < n; k++) begin
      int idx;
      idx = (p == 1) ? (last + 1 + k) % n : k;
      if (r[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic logic [LW-1:0] rline();
    logic [LW-1:0] v;
    for (int i = 0; i < LW/32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < NI; m++) begin
      m_busy[m]  = 1'b0;
      m_last[m]  = np(m) - 1;
      m_free[m]  = cyc;
      r_pend[m]  = 1'b0;
      to_drop[m] = '0;
    end
  endtask

  task automatic model_check(input int m);
    logic [3:0] pr;
    logic [3:0] exp_resp;
    int w;
    pr = p_rd[m] | p_wr[m];
    if (!m_busy[m] && (cyc - 1 >= m_free[m]) && pr != 4'd0) begin
      w = pick(pr, m_last[m], np(m), pol(m));
      m_busy[m] = 1'b1;
      m_g[m]    = w;
      e_w[m]    = p_wr[m][w];
      e_ma[m]   = p_ad[m][w*AW +: AW];
      e_wd[m]   = p_wd[m][w*LW +: LW];
    end
    if (m_busy[m]) begin
      chk($sformatf("i%0d port_active", m), o_act[m], 1 << m_g[m]);
      chk($sformatf("i%0d mem_read", m), o_mr[m], !e_w[m]);
      chk($sformatf("i%0d mem_write", m), o_mw[m], e_w[m]);
      chk($sformatf("i%0d mem_address", m), o_ma[m], e_ma[m]);
      chk($sformatf("i%0d mem_wdata", m), o_mwd[m], e_wd[m]);
    end else begin
      chk($sformatf("i%0d idle outputs", m), {o_act[m], o_mr[m], o_mw[m]}, 0);
    end
    exp_resp = (m_busy[m] && mresp[m]) ? 4'(1 << m_g[m]) : 4'd0;
    chk($sformatf("i%0d req_resp", m), o_resp[m], exp_resp);
    if (exp_resp != 4'd0) begin
      chk($sformatf("i%0d req_rdata", m), o_rdata[m], mrd[m]);
      if (gn[m] < 128) begin
        glog[m][gn[m]] = m_g[m];
        gn[m] = gn[m] + 1;
      end
      m_busy[m] = 1'b0;
      m_last[m] = m_g[m];
      m_free[m] = cyc + 2;
      if (drop[m] || (rnd[m] && $urandom_range(1) == 0)) to_drop[m][m_g[m]] = 1'b1;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    for (int m = 0; m < NI; m++) begin
      p_rd[m] = rd[m];
      p_wr[m] = wr[m];
      p_ad[m] = ad[m];
      p_wd[m] = wd[m];
      mresp[m] = 1'b0;
      mrd[m]   = '0;
      if (r_pend[m]) begin
        r_cnt[m]--;
        if (r_cnt[m] == 0) begin
          mresp[m]  = 1'b1;
          mrd[m]    = r_data[m];
          r_pend[m] = 1'b0;
        end
      end else if (r_en[m] && reset_n && (o_mr[m] || o_mw[m])) begin
        r_pend[m] = 1'b1;
        if (rnd[m]) begin
          r_lat[m]  = 1 + $urandom_range(4);
          r_data[m] = rline();
        end
        r_cnt[m] = r_lat[m];
      end
      for (int p = 0; p < np(m); p++) begin
        if (to_drop[m][p]) begin
          rd[m][p] = 1'b0;
          wr[m][p] = 1'b0;
        end
        if (rnd[m] && !rd[m][p] && !wr[m][p] && $urandom_range(2) == 0) begin
          int k;
          k = $urandom_range(2);
          rd[m][p] = (k != 1);
          wr[m][p] = (k != 0);
          ad[m][p*AW +: AW] = $urandom;
          wd[m][p*LW +: LW] = rline();
        end
      end
      to_drop[m] = '0;
    end
    #1;
    if (reset_n) for (int m = 0; m < NI; m++) model_check(m);
  endtask

  task automatic wait_resp(input int m, input int maxc, output int took);
    took = -1;
    for (int i = 1; i <= maxc; i++) begin
      tick();
      if (o_resp[m] != 4'd0) begin
        took = i;
        break;
      end
    end
    chk($sformatf("i%0d resp within bound", m), took > 0, 1'b1);
  endtask

  task automatic settle();
    for (int m = 0; m < NI; m++) begin
      rd[m] = '0;
      wr[m] = '0;
    end
    for (int i = 0; i < 20; i++) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int took;
    int ones;
    int exp4[6];
    exp4 = '{0, 2, 3, 0, 2, 3};
    for (int m = 0; m < NI; m++) begin
      rd[m] = '0; wr[m] = '0; ad[m] = '0; wd[m] = '0;
      mrd[m] = '0; mresp[m] = 1'b0;
      r_en[m] = 1'b1; r_lat[m] = 2; r_data[m] = '0;
      drop[m] = 1'b0; rnd[m] = 1'b0; gn[m] = 0;
    end
    model_reset();
    tick();
    for (int m = 0; m < NI; m++)
      chk($sformatf("i%0d reset outputs", m),
          {o_act[m], o_resp[m], o_mr[m], o_mw[m], o_ma[m]}, 0);
    tick();
    reset_n = 1'b1;
    model_reset();
    tick();

    // single read on port 1, memory answers 5 cycles after mem_read
    rd[0][1] = 1'b1;
    ad[0][AW +: AW] = 32'h0000_1040;
    r_lat[0] = 5;
    r_data[0] = {32{8'hA5}};
    drop[0] = 1'b1;
    tick();
    chk("t1 mem_read T+1", o_mr[0], 1'b1);
    chk("t1 mem_address", o_ma[0], 32'h0000_1040);
    chk("t1 port_active", o_act[0], 4'b0010);
    wait_resp(0, 20, took);
    chk("t1 resp latency", took, 5);
    chk("t1 req_resp", o_resp[0], 4'b0010);
    chk("t1 req_rdata", o_rdata[0], {32{8'hA5}});
    settle();

    // RR vs fixed priority under continuous port0 read + port1 write
    reset_n = 1'b0;
    #1;
    model_reset();
    tick();
    reset_n = 1'b1;
    model_reset();
    for (int m = 0; m < 2; m++) begin
      gn[m] = 0; drop[m] = 1'b0; r_lat[m] = 2; r_data[m] = rline();
      rd[m][0] = 1'b1;
      wr[m][1] = 1'b1;
      ad[m] = {32'h0000_2200, 32'h0000_1100};
      wd[m][LW +: LW] = rline();
      wd[m][0 +: LW]  = rline();
    end
    for (int i = 0; i < 40; i++) tick();
    for (int k = 0; k < 4; k++) chk($sformatf("t2 rr order %0d", k), glog[0][k], k % 2);
    ones = 0;
    for (int k = 0; k < gn[1]; k++) ones += glog[1][k];
    chk("t3 fixed grant count", gn[1] >= 3, 1'b1);
    chk("t3 fixed port1 grants", ones, 0);
    settle();

    // 4 ports, 0/2/3 requesting continuously
    gn[2] = 0; r_lat[2] = 1; drop[2] = 1'b0;
    rd[2] = 4'b1101;
    for (int p = 0; p < 4; p++) ad[2][p*AW +: AW] = 32'h4000 + p * 32'h40;
    for (int i = 0; i < 30; i++) tick();
    for (int k = 0; k < 6; k++) chk($sformatf("t4 rr4 order %0d", k), glog[2][k], exp4[k]);
    settle();

    // address change while BUSY must not reach downstream
    drop[0] = 1'b1; r_lat[0] = 6;
    rd[0][0] = 1'b1;
    ad[0][0 +: AW] = 32'h100;
    tick();
    tick();
    ad[0][0 +: AW] = 32'h200;
    wait_resp(0, 20, took);
    chk("t5 address held", o_ma[0], 32'h100);
    settle();

    // reset mid-BUSY, stray mem_resp, then normal grant
    r_lat[0] = 8;
    rd[0][0] = 1'b1;
    tick(); tick(); tick();
    chk("t6 busy before reset", o_act[0], 4'b0001);
    reset_n = 1'b0;
    #1;
    chk("t6 outputs cleared", {o_act[0], o_resp[0], o_mr[0], o_mw[0], o_ma[0], o_mwd[0]}, 0);
    rd[0] = '0;
    model_reset();
    tick(); tick();
    reset_n = 1'b1;
    model_reset();
    r_en[0] = 1'b0;
    tick();
    mresp[0] = 1'b1;
    mrd[0] = {LW{1'b1}};
    #1;
    chk("t6 stray mem_resp", o_resp[0], 4'b0000);
    tick(); tick();
    r_en[0] = 1'b1; r_lat[0] = 3;
    rd[0][0] = 1'b1;
    ad[0][0 +: AW] = 32'h300;
    wait_resp(0, 20, took);
    chk("t6 regrant resp", o_resp[0], 4'b0001);
    chk("t6 regrant address", o_ma[0], 32'h300);
    settle();

    // randomized traffic on all instances
    for (int m = 0; m < NI; m++) begin
      rnd[m] = 1'b1;
      drop[m] = 1'b0;
    end
    for (int i = 0; i < 1500; i++) tick();
    for (int m = 0; m < NI; m++) rnd[m] = 1'b0;
    settle();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
